// File: rtl/ysyx_22040895_ifu_if.sv
// rtl/ysyx_22040895_ifu_if.sv - fetch-unit bundle: imem request/response, redirect and decode handoff
interface ysyx_22040895_ifu_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] pc;

   modport master (
      output req_valid, req_addr, inst_valid, inst, pc,
      input  req_ready, resp_valid, resp_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  req_valid, req_addr, inst_valid, inst, pc,
      output req_ready, resp_valid, resp_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/ysyx_22040895_ifu.sv
// rtl/ysyx_22040895_ifu.sv - in-order instruction fetch unit with response buffer and redirect kill tracking
module ysyx_22040895_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [63:0] imem_req_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o
);
   localparam int             AW      = $clog2(DEPTH);
   localparam int             CW      = AW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] kill_q, kill_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [31:0]   inst_buf_q [DEPTH];
   logic [63:0]   pc_buf_q   [DEPTH];

   logic [CW-1:0] outstanding;
   logic          req_fire;
   logic          resp_kill;
   logic          resp_live;
   logic          push;
   logic          pop;
   logic [63:0]   target_pc;

   always_comb begin
      // killed + in-flight + buffered never exceeds DEPTH, so the sum fits in CW bits
      outstanding      = inflight_q + kill_q + count_q;
      imem_req_valid_o = !rst && !redirect_valid_i && (outstanding < DEPTH_C);
      imem_req_addr_o  = fetch_pc_q;
      req_fire         = imem_req_valid_o && imem_req_ready_i;

      resp_kill = imem_resp_valid_i && (kill_q != '0);
      resp_live = imem_resp_valid_i && (kill_q == '0) && (inflight_q != '0);

      inst_valid_o = !rst && (count_q != '0);
      inst_o       = inst_valid_o ? inst_buf_q[head_q] : 32'h0;
      pc_o         = inst_valid_o ? pc_buf_q[head_q]   : 64'h0;

      pop       = inst_valid_o && inst_ready_i;
      push      = resp_live && !redirect_valid_i;
      target_pc = {redirect_pc_i[63:2], 2'b00};
   end

   always_comb begin
      fetch_pc_d = req_fire  ? fetch_pc_q + 64'd4 : fetch_pc_q;
      resp_pc_d  = resp_live ? resp_pc_q + 64'd4  : resp_pc_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_live);
      kill_d     = kill_q - CW'(resp_kill);
      head_d     = pop  ? head_q + AW'(1) : head_q;
      tail_d     = push ? tail_q + AW'(1) : tail_q;
      count_d    = count_q + CW'(push) - CW'(pop);

      if (redirect_valid_i) begin
         // everything still owed by memory becomes garbage; this cycle's response is already spent
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         kill_d     = kill_q + inflight_q - CW'(resp_live || resp_kill);
         inflight_d = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         kill_q     <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_buf_q[tail_q] <= imem_resp_data_i;
         pc_buf_q[tail_q]   <= resp_pc_q;
      end
   end
endmodule
